mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter VLAT, 2, memory cycles per video read (1..15).
REQ-002 Parameter VGAP, 2, minimum CPU-owned cycles between consecutive video accesses (1..15).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cpu_adr  in  24  CPU byte address.
REQ-006 cpu_rd, cpu_wr, cpu_ben  in  1 each  CPU read, write, byte-enable strobes.
REQ-007 cpu_wdata  in  32  CPU store data, byte pre-replicated.
REQ-008 cpu_rdata  out  32  memory word returned to CPU.
REQ-009 stallX  out  1  registered CPU stall.
REQ-010 vreq  in  1  video word request, level, held until vack.
REQ-011 vadr  in  18  video word address, stable while vreq high.
REQ-012 vack  out  1  one-cycle pulse, vdata valid.
REQ-013 vdata  out  32  captured video word.
REQ-014 mem_adr  out  18  memory word address.
REQ-015 mem_wdata  out  32, mem_be  out  4, mem_we  out  1, mem_oe  out  1  memory port.

Function
REQ-016 States: IDLE (CPU owns memory, stallX=0), VID (video owns memory, stallX=1).
REQ-017 IDLE: mem_adr=cpu_adr[19:2], mem_oe=cpu_rd, mem_we=cpu_wr, mem_wdata=cpu_wdata, combinational pass-through, zero added latency.
REQ-018 mem_be=4'b1111 when cpu_ben=0; else one-hot bit cpu_adr[1:0] (00->0001, 11->1000).
REQ-019 cpu_rdata=mem_rdata always; byte selection is the CPU's responsibility.
REQ-020 IDLE->VID at clock edge where vreq=1 and gap counter=0; CPU keeps memory in the cycle vreq is first sampled.
REQ-021 stallX shall be a flop set on entering VID and cleared on leaving; it shall never depend combinationally on cpu_rd/cpu_wr.
REQ-022 VID: mem_adr=vadr, mem_oe=1, mem_we=0, mem_be=4'b1111, held exactly VLAT cycles via cycle counter.
REQ-023 On last VID cycle, mem_rdata captured into vdata; next cycle state=IDLE, vack=1 for one cycle, gap counter loaded with VGAP.
REQ-024 Gap counter decrements each IDLE cycle to 0; video blocked while nonzero, bounding CPU starvation.
REQ-025 cpu_rd/cpu_wr asserted during VID (illegal) shall be ignored: mem_we stays 0.
REQ-026 vreq dropped mid-VID: access completes, vack still pulses.
REQ-027 vreq still high at vack cycle: treated as new request, subject to gap.
REQ-028 vdata holds last captured value until next capture.

Reset
REQ-029 rst=0 asynchronously forces IDLE, stallX=0, vack=0, vdata=0, cycle and gap counters=0, including mid-VID; in-flight video access abandoned without vack.
REQ-030 After rst release, first video grant possible at first edge with vreq=1.

Structure
REQ-031 Shared package holds state encoding (IDLE=0, VID=1), VLAT/VGAP defaults, video address width 18.
REQ-032 Single module; no sub-module is natural (two 4-bit counters, one state flop, muxes).

Verification
REQ-033 CPU word write adr 24'h000104, data 32'hDEADBEEF, no vreq -> same cycle mem_adr=18'h41, mem_we=1, mem_be=4'hF, stallX=0.
REQ-034 CPU byte write adr 24'h000107, ben=1 -> mem_be=4'b1000.
REQ-035 vreq with vadr=18'h3F000, VLAT=2, mem_rdata=32'h12345678 -> stallX high 2 cycles, mem_adr=18'h3F000, then vack pulse, vdata=32'h12345678, stallX=0.
REQ-036 vreq held continuously, VGAP=2 -> stallX pattern 1,1,0,0 repeating; CPU accesses complete in every stallX=0 cycle.
REQ-037 rst pulled low in first VID cycle -> stallX=0 and mem_oe follows cpu_rd immediately, no vack; after release next vreq granted normally.
REQ-038 cpu_wr=1 forced during VID -> mem_we remains 0, video data unaffected.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/video memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned CPU_ADR_W = 24;
    localparam int unsigned VADR_W    = 18;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned VLAT_DEF  = 2;
    localparam int unsigned VGAP_DEF  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        VID  = 1'b1
    } state_t;

    // Full word when byte enable is low, otherwise the single lane addressed by adr[1:0].
    function automatic logic [BE_W-1:0] byte_lanes(input logic ben, input logic [1:0] lo);
        logic [BE_W-1:0] be;
        if (!ben) begin
            be = '1;
        end else begin
            be = BE_W'(1) << lo;
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU passes straight through, video steals fixed-length
// read slots separated by a guaranteed run of CPU-owned cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned VLAT = VLAT_DEF,
    parameter int unsigned VGAP = VGAP_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_ADR_W-1:0] cpu_adr,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic                 cpu_ben,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 stallX,
    input  logic                 vreq,
    input  logic [VADR_W-1:0]    vadr,
    output logic                 vack,
    output logic [DATA_W-1:0]    vdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [VADR_W-1:0]    mem_adr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [BE_W-1:0]      mem_be,
    output logic                 mem_we,
    output logic                 mem_oe
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] gap;
    logic             grant;
    logic             last;
    logic             unused_adr_hi;

    assign unused_adr_hi = ^cpu_adr[CPU_ADR_W-1:VADR_W+2];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; gap holds the CPU cycles still owed including the current one,
    // so a grant is allowed on the last of them.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (vreq && (gap <= CNT_W'(1))) begin
                    grant     = 1'b1;
                    state_nxt = VID;
                end
            end
            VID: begin
                if (cyc == '0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slot/gap counters, stall flag, video handshake and capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallX <= 1'b0;
            vack   <= 1'b0;
            vdata  <= '0;
            cyc    <= '0;
            gap    <= '0;
        end else begin
            vack <= last;
            if (grant) begin
                stallX <= 1'b1;
            end else if (last) begin
                stallX <= 1'b0;
            end
            if (grant) begin
                cyc <= CNT_W'(VLAT - 1);
            end else if ((state == VID) && (cyc != '0)) begin
                cyc <= cyc - CNT_W'(1);
            end
            if (last) begin
                gap <= CNT_W'(VGAP);
            end else if ((state == IDLE) && (gap != '0)) begin
                gap <= gap - CNT_W'(1);
            end
            if (last) begin
                vdata <= mem_rdata;
            end
        end
    end

    // Memory port mux; CPU strobes are ignored while video owns the bus.
    always_comb begin
        mem_adr   = cpu_adr[VADR_W+1:2];
        mem_oe    = cpu_rd;
        mem_we    = cpu_wr;
        mem_wdata = cpu_wdata;
        mem_be    = byte_lanes(cpu_ben, cpu_adr[1:0]);
        if (state == VID) begin
            mem_adr = vadr;
            mem_oe  = 1'b1;
            mem_we  = 1'b0;
            mem_be  = '1;
        end
    end

    assign cpu_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (VLAT=2, VGAP=2).
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [23:0] cpu_adr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_ben;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stallX;
    logic        vreq;
    logic [17:0] vadr;
    logic        vack;
    logic [31:0] vdata;
    logic [31:0] mem_rdata;
    logic [17:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_oe;

    int errors;
    int checks;

    localparam logic [7:0] STALL_PAT = 8'b0011_0011;
    localparam logic [7:0] VACK_PAT  = 8'b0100_0100;

    mem_arbiter #(.VLAT(2), .VGAP(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_adr(cpu_adr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_ben(cpu_ben),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stallX(stallX),
        .vreq(vreq), .vadr(vadr), .vack(vack), .vdata(vdata),
        .mem_rdata(mem_rdata), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b0;
        cpu_adr   = '0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_ben   = 1'b0;
        cpu_wdata = '0;
        vreq      = 1'b0;
        vadr      = '0;
        mem_rdata = '0;

        // Reset state
        #2;
        check("rst_stall", 32'(stallX), 32'd0);
        check("rst_vack",  32'(vack),   32'd0);
        check("rst_vdata", vdata,       32'd0);
        check("rst_oe",    32'(mem_oe), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // CPU word write pass-through
        @(negedge clk);
        cpu_adr = 24'h000104; cpu_wr = 1'b1; cpu_wdata = 32'hDEADBEEF; mem_rdata = 32'h0BADF00D;
        #1;
        check("wr_adr",   32'(mem_adr),   32'h41);
        check("wr_we",    32'(mem_we),    32'd1);
        check("wr_be",    32'(mem_be),    32'hF);
        check("wr_wdata", mem_wdata,      32'hDEADBEEF);
        check("wr_stall", 32'(stallX),    32'd0);
        check("rdata",    cpu_rdata,      32'h0BADF00D);

        // Byte enables
        cpu_adr = 24'h000107; cpu_ben = 1'b1;
        #1;
        check("be_b3", 32'(mem_be), 32'h8);
        cpu_adr = 24'h000105;
        #1;
        check("be_b1", 32'(mem_be), 32'h2);

        // Single video read
        @(negedge clk);
        cpu_wr = 1'b0; cpu_ben = 1'b0; cpu_rd = 1'b1; cpu_adr = 24'h000200;
        vreq = 1'b1; vadr = 18'h3F000; mem_rdata = 32'h12345678;
        #1;
        check("v_first_stall", 32'(stallX),  32'd0);
        check("v_first_adr",   32'(mem_adr), 32'h80);
        @(negedge clk); #1;
        check("v1_stall", 32'(stallX),  32'd1);
        check("v1_adr",   32'(mem_adr), 32'h3F000);
        check("v1_oe",    32'(mem_oe),  32'd1);
        check("v1_be",    32'(mem_be),  32'hF);
        @(negedge clk); #1;
        check("v2_stall", 32'(stallX), 32'd1);
        check("v2_vack",  32'(vack),   32'd0);
        @(negedge clk); #1;
        check("v_ack",       32'(vack),    32'd1);
        check("v_data",      vdata,        32'h12345678);
        check("v_ack_stall", 32'(stallX),  32'd0);
        check("v_ack_adr",   32'(mem_adr), 32'h80);
        vreq = 1'b0;
        mem_rdata = 32'h55AA55AA;
        @(negedge clk); #1;
        check("v_ack_pulse", 32'(vack), 32'd0);
        check("v_data_hold", vdata,     32'h12345678);
        repeat (2) @(negedge clk);

        // Continuous vreq with CPU writes forced every cycle
        cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_adr = 24'h000010;
        vreq = 1'b1; vadr = 18'h00ABC; mem_rdata = 32'hA5A5A5A5;
        #1;
        check("c_pre_stall", 32'(stallX), 32'd0);
        check("c_pre_we",    32'(mem_we), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            check($sformatf("c_stall%0d", i), 32'(stallX), 32'(STALL_PAT[i]));
            check($sformatf("c_we%0d", i),    32'(mem_we), 32'(!STALL_PAT[i]));
            check($sformatf("c_vack%0d", i),  32'(vack),   32'(VACK_PAT[i]));
            check($sformatf("c_adr%0d", i),   32'(mem_adr),
                  STALL_PAT[i] ? 32'h00ABC : 32'h4);
        end
        check("c_vdata", vdata, 32'hA5A5A5A5);
        vreq = 1'b0;

        // Reset during first video cycle
        @(negedge clk);
        cpu_wr = 1'b0; vreq = 1'b1; vadr = 18'h01234; mem_rdata = 32'hCAFEF00D;
        @(negedge clk); #1;
        check("r_vid_stall", 32'(stallX), 32'd1);
        rst = 1'b0; cpu_rd = 1'b1; cpu_adr = 24'h000300;
        #1;
        check("r_stall", 32'(stallX),  32'd0);
        check("r_oe",    32'(mem_oe),  32'd1);
        check("r_adr",   32'(mem_adr), 32'hC0);
        check("r_vack",  32'(vack),    32'd0);
        check("r_vdata", vdata,        32'd0);
        cpu_rd = 1'b0;
        #1;
        check("r_oe_follow", 32'(mem_oe), 32'd0);
        @(negedge clk); #1;
        check("r_held_vack",  32'(vack),   32'd0);
        check("r_held_stall", 32'(stallX), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rr_stall1", 32'(stallX),  32'd1);
        check("rr_adr",    32'(mem_adr), 32'h01234);
        @(negedge clk); #1;
        check("rr_stall2", 32'(stallX), 32'd1);
        check("rr_vack0",  32'(vack),   32'd0);
        @(negedge clk); #1;
        check("rr_vack",  32'(vack),   32'd1);
        check("rr_vdata", vdata,       32'hCAFEF00D);
        check("rr_stall", 32'(stallX), 32'd0);
        vreq = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
